// File: rtl/echo_tof_detector.sv
// Sonar echo time-of-flight detector: counts filtered samples after a ping, skips a
// blanking window, then reports the first debounced above-threshold run, or a miss.
module echo_tof_detector #(
  parameter int N  = 16,
  parameter int CW = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                valid,
  input  logic signed [N-1:0] Y,
  input  logic        [N-1:0] threshold,
  input  logic        [3:0]   hold,
  input  logic        [CW-1:0] blank_len,
  input  logic        [CW-1:0] timeout,
  output logic                busy,
  output logic                done,
  output logic                hit,
  output logic        [CW-1:0] tof,
  output logic        [N-1:0] peak
);

  typedef enum logic [1:0] {S_IDLE, S_BLANK, S_LISTEN, S_DONE} state_t;

  state_t state, state_nxt;

  logic [N-1:0]  thr_q;
  logic [3:0]    hold_q;
  logic [CW-1:0] blank_q;
  logic [CW-1:0] timeout_q;
  logic [CW-1:0] idx;
  logic [3:0]    run;
  logic [CW-1:0] run_start;
  logic [N-1:0]  peak_acc;

  logic [N-1:0]  mag;
  logic [N-1:0]  peak_nxt;
  logic [3:0]    run_inc;
  logic [CW-1:0] run_first;
  logic          above;
  logic          is_last;
  logic          is_blank_end;
  logic          confirm;

  // The most negative sample has no positive counterpart in N bits, so it saturates.
  always_comb begin
    if (!Y[N-1])
      mag = Y;
    else if (Y[N-2:0] == '0)
      mag = {1'b0, {(N-1){1'b1}}};
    else
      mag = ~Y + 1'b1;
  end

  assign above        = (mag >= thr_q);
  assign peak_nxt     = (mag > peak_acc) ? mag : peak_acc;
  assign run_inc      = run + 4'd1;
  assign run_first    = (run == 4'd0) ? idx : run_start;
  assign is_last      = (idx == timeout_q - 1'b1);
  assign is_blank_end = (idx == blank_q - 1'b1);
  assign confirm      = (state == S_LISTEN) && valid && above && (run_inc == hold_q);

  always_ff @(posedge clk) begin
    if (rst)
      state <= S_IDLE;
    else
      state <= state_nxt;
  end

  // NOTE: every output of this block gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          if (timeout == '0)
            state_nxt = S_DONE;
          else if (blank_len != '0)
            state_nxt = S_BLANK;
          else
            state_nxt = S_LISTEN;
        end
      end
      S_BLANK: begin
        busy = 1'b1;
        // Expiry is checked first: a window no longer than the blanking is a miss.
        if (valid) begin
          if (is_last)
            state_nxt = S_DONE;
          else if (is_blank_end)
            state_nxt = S_LISTEN;
        end
      end
      S_LISTEN: begin
        busy = 1'b1;
        if (valid && (confirm || is_last))
          state_nxt = S_DONE;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (rst) begin
      thr_q     <= '0;
      hold_q    <= 4'd1;
      blank_q   <= '0;
      timeout_q <= '0;
      idx       <= '0;
      run       <= '0;
      run_start <= '0;
      peak_acc  <= '0;
      hit       <= 1'b0;
      tof       <= '0;
      peak      <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            thr_q     <= threshold;
            hold_q    <= (hold == 4'd0) ? 4'd1 : hold;
            blank_q   <= blank_len;
            timeout_q <= timeout;
            idx       <= '0;
            run       <= '0;
            run_start <= '0;
            peak_acc  <= '0;
            hit       <= 1'b0;
            tof       <= '0;
            peak      <= '0;
          end
        end
        S_BLANK: begin
          if (valid)
            idx <= idx + 1'b1;
        end
        S_LISTEN: begin
          if (valid) begin
            idx      <= idx + 1'b1;
            peak_acc <= peak_nxt;
            if (above) begin
              run <= run_inc;
              if (run == 4'd0)
                run_start <= idx;
            end else begin
              run <= '0;
            end
            // A confirming sample on the last index still counts as a hit.
            if (confirm) begin
              hit  <= 1'b1;
              tof  <= run_first;
              peak <= peak_nxt;
            end else if (is_last) begin
              peak <= peak_nxt;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/echo_tof_detector.md
# echo_tof_detector

Downstream consumer of the biquad filter's output stream (`Y` / `valid`) in the sonar receive chain. On each `start` ping it counts filtered samples, ignores a blanking window while the transducer rings down, then looks for the first echo: a debounced run of samples whose magnitude meets a threshold. It reports time-of-flight in sample units, a hit/miss flag and the peak magnitude, and is read by the control/Wishbone side.

## Interface
Parameters:
- `N`, 16, sample width; the filter's `Y` is a two's-complement sample.
- `CW`, 16, width of the sample-index, blanking, timeout and TOF counters.

Ports:
- `clk`  in  1  single system clock; everything is on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle pulse that begins a measurement; ignored while `busy`.
- `valid`  in  1  sample strobe from the filter.
- `Y`  in  N  filtered sample, signed.
- `threshold`  in  N  unsigned magnitude threshold.
- `hold`  in  4  consecutive samples required to confirm an echo; 0 is treated as 1.
- `blank_len`  in  CW  number of samples ignored after `start`.
- `timeout`  in  CW  total number of samples in the measurement window.
- `busy`  out  1  high from the cycle after accepted `start` until `done`.
- `done`  out  1  one-cycle pulse when the result is valid.
- `hit`  out  1  1 = echo found, 0 = timeout.
- `tof`  out  CW  sample index of the first sample of the confirming run; 0 on a miss.
- `peak`  out  N  maximum magnitude seen during LISTEN.

## Operation
- Configuration inputs (`threshold`, `hold`, `blank_len`, `timeout`) are latched on the accepted `start` cycle. Later changes do not affect a running measurement.
- States:
  - IDLE: `start` is accepted here only. Next state is BLANK if `blank_len` != 0, else LISTEN. If `timeout` == 0, next state is DONE instead, with `hit`=0.
  - BLANK: each `valid` increments `idx`. On the sample with `idx` == `blank_len`-1, go to LISTEN.
  - LISTEN: each `valid` computes `mag` and updates `peak`. If `mag` >= `threshold`: on the first sample of a run, `run_start` <= `idx`; then `run` increments. If `mag` < `threshold`, `run` clears to 0. `idx` increments on every sample.
  - DONE: one cycle; `done` asserted; return to IDLE.
- Sample index: the first `valid` after the `start` cycle is index 0. A `valid` coincident with `start` is not consumed.
- Magnitude: `mag` = |Y|. Y = -2^(N-1) saturates to 2^(N-1)-1. Comparison is unsigned, N bits.
- Detection: when `run` reaches `hold`, go to DONE with `hit`=1 and `tof`=`run_start`.
- Timeout: after processing the sample with `idx` == `timeout`-1 in BLANK or LISTEN without a detection, go to DONE with `hit`=0 and `tof`=0.
- If the same sample both confirms an echo and is index `timeout`-1, the hit wins.
- If `timeout` <= `blank_len`, the window expires during BLANK and the result is a miss with `peak`=0.
- `hit`, `tof` and `peak` are updated at entry to DONE and held until the next accepted `start`. On that `start` they clear to 0.
- `start` while `busy` is ignored, with no effect on state or results.
- `rst` at any time returns the block to IDLE, clears all counters and outputs, and abandons any measurement in progress.

## Timing
- Reset values: `busy`=0, `done`=0, `hit`=0, `tof`=0, `peak`=0.
- `busy` rises the cycle after the accepted `start` and falls in the same cycle that `done` pulses.
- Latency: `done` pulses exactly one cycle after the clock edge that consumed the deciding sample. With `timeout`=0, `done` pulses one cycle after `start`.
- No backpressure: every `valid` in BLANK/LISTEN is consumed in its own cycle. `valid` on back-to-back cycles is fully supported.
- `valid` in IDLE or DONE is dropped.

## Test plan
- Basic hit. Stimulus: `blank_len`=4, `timeout`=100, `threshold`=1000, `hold`=3. Samples idx 0–3 = 5000 (blanked), idx 4–9 = 100, idx 10–12 = 1200. Response: `done` one cycle after idx 12, `hit`=1, `tof`=10, `peak`=1200.
- Debounce reset. Stimulus: same config; idx 10–11 = 1200, idx 12 = 50, idx 13–15 = -1500. Response: `hit`=1, `tof`=13, `peak`=1500.
- Miss and saturation. Stimulus: `timeout`=20, all samples 10 except one sample of -32768 at idx 8, with `hold`=2. Response: `done` after idx 19, `hit`=0, `tof`=0, `peak`=32767.
- Hit/timeout tie. Stimulus: `timeout`=12, `hold`=1, threshold crossed only at idx 11. Response: `hit`=1, `tof`=11.
- Edge cases:
  - `timeout`=0: `done` one cycle after `start`, `hit`=0.
  - `start` while `busy`: ignored.
  - `valid` coincident with `start`: not counted, so `tof` is offset accordingly.
- Reset mid-LISTEN. Stimulus: assert `rst` at idx 6. Response: all outputs 0, state IDLE; a fresh `start` then measures correctly.
